// File: rtl/mips_step_ctrl.sv
// mips_step_ctrl: execution-rate controller producing a one-cycle clock enable for the multicycle MIPS core
// Ports:
//   clk       PLL clock, all logic on its rising edge
//   reset     synchronous active-low reset
//   mode      00 halt, 01 single step, 10 divided rate, 11 free-run
//   rate_sel  selects DIV0..DIV3 in divided mode
//   step_btn  raw asynchronous pushbutton, active-high
//   cpu_en    registered one-cycle enable to the core
//   tick_led  toggles on every cpu_en
//   cycle_cnt saturating count of cpu_en pulses
module mips_step_ctrl #(
  parameter int DIV_W      = 26,
  parameter int DIV0       = 50000000,
  parameter int DIV1       = 12500000,
  parameter int DIV2       = 500000,
  parameter int DIV3       = 5000,
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [1:0]       rate_sel,
  input  logic             step_btn,
  output logic             cpu_en,
  output logic             tick_led,
  output logic [CNT_W-1:0] cycle_cnt
);
  logic             sync1, btn_s, btn_db, btn_db_q;
  logic [DEB_W-1:0] deb_cnt;
  logic [DIV_W-1:0] div_cnt, div_last, div_next;
  logic [1:0]       mode_q, rate_q;
  logic             change, en_next;
  always_comb begin
    div_last = rate_sel == 2'd0 ? DIV_W'(DIV0 - 1) :
               rate_sel == 2'd1 ? DIV_W'(DIV1 - 1) :
               rate_sel == 2'd2 ? DIV_W'(DIV2 - 1) : DIV_W'(DIV3 - 1);
    // a mode or rate change restarts the divider and suppresses the enable for that cycle
    change   = mode != mode_q || rate_sel != rate_q;
    div_next = (change || mode != 2'b10 || div_cnt == div_last) ? '0 : div_cnt + DIV_W'(1);
    // step pulses only on a debounced rise seen while already in step mode; other rises are dropped
    en_next  = !change && (mode == 2'b11 ||
                           (mode == 2'b10 && div_cnt == div_last) ||
                           (mode == 2'b01 && btn_db && !btn_db_q));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1     <= 1'b0;
      btn_s     <= 1'b0;
      btn_db    <= 1'b0;
      btn_db_q  <= 1'b0;
      deb_cnt   <= '0;
      div_cnt   <= '0;
      mode_q    <= mode;
      rate_q    <= rate_sel;
      cpu_en    <= 1'b0;
      tick_led  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      sync1    <= step_btn;
      btn_s    <= sync1;
      btn_db_q <= btn_db;
      if (btn_s == btn_db)
        deb_cnt <= '0;
      else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        btn_db  <= btn_s;
        deb_cnt <= '0;
      end else
        deb_cnt <= deb_cnt + DEB_W'(1);
      div_cnt <= div_next;
      mode_q  <= mode;
      rate_q  <= rate_sel;
      cpu_en  <= en_next;
      if (cpu_en) begin
        tick_led <= ~tick_led;
        if (~&cycle_cnt) cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mips_step_ctrl.sv
// tb_mips_step_ctrl: directed self-checking bench for mips_step_ctrl
module tb_mips_step_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode, rate_sel;
  logic       step_btn;
  logic       cpu_en, tick_led;
  logic [3:0] cycle_cnt;
  int checks = 0, errors = 0;
  int pat, cnt, first, toggles;
  logic prev;
  mips_step_ctrl #(.DIV_W(8), .DIV0(3), .DIV1(5), .DIV2(2), .DIV3(1),
                   .DEB_CYCLES(4), .DEB_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .rate_sel(rate_sel), .step_btn(step_btn),
    .cpu_en(cpu_en), .tick_led(tick_led), .cycle_cnt(cycle_cnt));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  initial begin
    reset = 1'b0; mode = 2'b10; rate_sel = 2'd0; step_btn = 1'b0;
    repeat (3) cyc();
    chk("rst_en", cpu_en, 0);
    chk("rst_led", tick_led, 0);
    chk("rst_cnt", cycle_cnt, 0);
    reset = 1'b1;
    cyc(); cyc();
    chk("div0_pre", cpu_en, 0);
    cyc();
    chk("div0_first", cpu_en, 1);
    pat = 0;
    for (int i = 0; i < 15; i++) begin cyc(); pat = (pat << 1) | int'(cpu_en); end
    chk("div0_pat", pat, 15'b001001001001001);
    cyc();
    chk("div0_cnt", cycle_cnt, 6);
    chk("div0_led", tick_led, 0);
    rate_sel = 2'd1;
    pat = 0;
    for (int i = 0; i < 11; i++) begin cyc(); pat = (pat << 1) | int'(cpu_en); end
    chk("rate_sw_pat", pat, 11'b00000100001);
    cyc();
    chk("rate_sw_cnt", cycle_cnt, 8);
    mode = 2'b01; step_btn = 1'b1;
    cyc(); step_btn = 1'b0;
    cyc(); step_btn = 1'b1;
    cnt = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (cpu_en) begin cnt++; if (first == 0) first = i; end
    end
    chk("step_pulses", cnt, 1);
    chk("step_latency", first, 7);
    step_btn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin cyc(); cnt += int'(cpu_en); end
    chk("release_pulses", cnt, 0);
    chk("step_cnt", cycle_cnt, 9);
    mode = 2'b00; step_btn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin cyc(); cnt += int'(cpu_en); end
    mode = 2'b01;
    for (int i = 0; i < 10; i++) begin cyc(); cnt += int'(cpu_en); end
    chk("held_entry_pulses", cnt, 0);
    chk("held_entry_cnt", cycle_cnt, 9);
    mode = 2'b11;
    cyc();
    chk("free_change", cpu_en, 0);
    cyc();
    prev = tick_led; cnt = 0; toggles = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      cnt += int'(cpu_en);
      if (tick_led != prev) toggles++;
      prev = tick_led;
    end
    chk("free_en", cnt, 20);
    chk("free_toggles", toggles, 20);
    chk("free_sat", cycle_cnt, 15);
    mode = 2'b10; rate_sel = 2'd0;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("mid_rst_en", cpu_en, 0);
    chk("mid_rst_led", tick_led, 0);
    chk("mid_rst_cnt", cycle_cnt, 0);
    reset = 1'b1;
    pat = 0;
    for (int i = 0; i < 6; i++) begin cyc(); pat = (pat << 1) | int'(cpu_en); end
    chk("mid_rst_pat", pat, 6'b001001);
    rate_sel = 2'd3;
    pat = 0;
    for (int i = 0; i < 5; i++) begin cyc(); pat = (pat << 1) | int'(cpu_en); end
    chk("div1_pat", pat, 5'b01111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_step_ctrl.md
Name: mips_step_ctrl

Overview:
- Parametrised execution-rate controller for the multicycle MIPS core on the MAX10 board. It succeeds the fixed 1 s divider.
- Produces a single-cycle clock enable (cpu_en) for the FSM and datapath, which stay on the PLL clock.
- Enable source is selectable at runtime:
  - halt
  - debounced single-step button
  - one of four divided rates
  - free-run
- Also drives a heartbeat LED and a saturating executed-cycle counter for board debug.

Parameters:
- DIV_W, 26: width of divider counter.
- DIV0, 50000000: rate 0 divisor, in clk cycles per enable (1 Hz at 50 MHz).
- DIV1, 12500000: rate 1 divisor.
- DIV2, 500000: rate 2 divisor.
- DIV3, 5000: rate 3 divisor.
- DEB_CYCLES, 500000: cycles the synchronised button must stay stable before it is accepted (10 ms).
- DEB_W, 20: width of debounce counter.
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk, input, 1: PLL clock; all logic on rising edge.
- reset, input, 1: synchronous, active-low reset.
- mode, input, 2: 00 halt, 01 step, 10 divided, 11 free-run.
- rate_sel, input, 2: selects DIV0..DIV3 in divided mode.
- step_btn, input, 1: raw asynchronous pushbutton, active-high.
- cpu_en, output, 1: registered one-cycle enable to the core.
- tick_led, output, 1: toggles on every cpu_en.
- cycle_cnt, output, CNT_W: number of cpu_en pulses issued, saturating.

Behaviour:
- Reset (reset=0 at a clk edge):
  - cpu_en=0, tick_led=0, cycle_cnt=0.
  - Divider count=0, debounce count=0.
  - Synchroniser flops=0, debounced level btn_db=0, previous mode/rate registers=current inputs.
  - Reset dominates all other events. Reset asserted mid-count or mid-debounce discards the progress.
- Button path:
  - 2-flop synchroniser, output btn_s.
  - Debounce counter clears whenever btn_s == btn_db.
  - Otherwise it increments. When it reaches DEB_CYCLES-1, btn_db <= btn_s and the counter clears.
  - Rise of btn_db = btn_db 0->1 transition.
- Step mode (01):
  - cpu_en=1 for exactly one cycle, the cycle after the btn_db rise.
  - Latency from a clean step_btn rise to cpu_en: 2 + DEB_CYCLES + 1 clk cycles.
  - Bounces shorter than DEB_CYCLES produce no pulse.
  - Release produces no pulse. Holding the button produces one pulse only.
- Divided mode (10):
  - Divider counts 0..DIVn-1. cpu_en=1 in the cycle after count == DIVn-1, and count wraps to 0.
  - Period is exactly DIVn cycles. DIVn=1 gives cpu_en every cycle. DIVn=0 is illegal.
- Free mode (11): cpu_en=1 every cycle, starting the cycle after mode is sampled as 11.
- Halt mode (00): cpu_en=0. Divider is held at 0.
- Mode/rate change:
  - Any change of mode or rate_sel (vs. the previous-value registers) clears the divider that cycle.
  - No cpu_en is produced in the change cycle. The first divided pulse comes exactly DIVn cycles after the change.
- Cross-mode button events:
  - A btn_db rise while not in step mode is dropped, not queued.
  - The debouncer keeps running in all modes, so entering step mode with the button held produces no pulse.
- tick_led inverts on every cycle where cpu_en=1.
- cycle_cnt:
  - Increments on every cycle where cpu_en=1.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
Bench parameters: DEB_CYCLES=4, DIV0=3, DIV1=5, CNT_W=4.
- Reset then divided, rate 0: hold reset low 3 cycles, release with mode=10, rate_sel=0 -> cpu_en pulses every 3rd cycle, first pulse 3 cycles after release. After 6 pulses: tick_led=0, cycle_cnt=6.
- Rate switch mid-count: rate 0, switch rate_sel to 1 one cycle after a pulse -> no pulse for 5 cycles, then period 5.
- Step with bounce: mode=01, step_btn toggles 1,0,1 at 1-cycle intervals then held high 10 cycles -> exactly one cpu_en, arriving 7 cycles after the final rise. Release gives no pulse.
- Step ignored outside step mode: mode=00, press and hold the button, then switch to 01 -> no cpu_en; cycle_cnt unchanged.
- Free-run saturation: mode=11 for 20 cycles -> cpu_en high continuously; cycle_cnt stops at 15; tick_led toggling every cycle.
- Reset mid-operation: mode=10 with divider at 2, assert reset one cycle -> all outputs 0 next cycle. After release, the first pulse comes a full DIV0 later.
